seq_bit_tx: RTL and testbench

Serial pattern transmitter that produces the single-bit stream consumed by the sequence detectors (e.g. the 1101 Mealy detector). A parallel pattern of up to MAX_LEN bits is captured on a start request and shifted out MSB-first, one bit per clock, optionally repeated back-to-back. It is the source end of the detector's `input_bit` interface and drives the detector benches and the top-level demo.

---
 rtl/seq_bit_tx.sv | 78 +++++++
 tb/tb_seq_bit_tx.sv | 127 ++++++++++++
 2 files changed

// File: rtl/seq_bit_tx.sv
// seq_bit_tx: captures a parallel pattern and shifts it out MSB-first, optionally repeated
module seq_bit_tx #(
    parameter int MAX_LEN = 16,
    parameter int LW      = $clog2(MAX_LEN + 1),
    parameter int RW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] data_in,
    input  logic [LW-1:0]      len,
    input  logic [RW-1:0]      repeat_cnt,
    output logic               output_bit,
    output logic               bit_valid,
    output logic               busy,
    output logic               done
);
    localparam int IW = $clog2(MAX_LEN);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [MAX_LEN-1:0] sreg, sreg_n;
    logic [IW-1:0] idx, idx_n, last, last_n;
    logic [RW-1:0] reps, reps_n;
    logic [LW-1:0] len_eff;
    assign len_eff = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
    // next-state logic: capture in IDLE, count bits and repetitions in SHIFT
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        idx_n   = idx;
        last_n  = last;
        reps_n  = reps;
        if (state == IDLE) begin
            if (start) begin
                sreg_n  = data_in;
                last_n  = IW'(len_eff - LW'(1));
                idx_n   = IW'(len_eff - LW'(1));
                reps_n  = repeat_cnt;
                state_n = (len_eff != '0) ? SHIFT : DONE;
            end
        end else if (state == SHIFT) begin
            if (idx != '0) begin
                idx_n = idx - IW'(1);
            end else if (reps != '0) begin
                reps_n = reps - RW'(1);
                idx_n  = last;
            end else begin
                state_n = DONE;
            end
        end else begin
            state_n = IDLE;
        end
    end
    // state and registered Moore outputs derived from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            idx        <= '0;
            last       <= '0;
            reps       <= '0;
            output_bit <= 1'b0;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            idx        <= idx_n;
            last       <= last_n;
            reps       <= reps_n;
            output_bit <= (state_n == SHIFT) & sreg_n[idx_n];
            bit_valid  <= state_n == SHIFT;
            busy       <= state_n != IDLE;
            done       <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_seq_bit_tx.sv
// tb_seq_bit_tx: directed scoreboard bench for the serial pattern transmitter
module tb_seq_bit_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [4:0]  len = '0;
    logic [3:0]  repeat_cnt = '0;
    logic        output_bit, bit_valid, busy, done;
    logic [3:0]  exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    seq_bit_tx dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .len(len),
        .repeat_cnt(repeat_cnt), .output_bit(output_bit), .bit_valid(bit_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s {valid,bit,busy,done} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [15:0] d, input logic [4:0] l, input logic [3:0] r,
                        input bit keep, input bit disturb, input string tag);
        int le, n, k, hits_exp, hits_obs;
        logic [3:0] e, dexp, dobs;
        logic b;
        le = (l > 16) ? 16 : int'(l);
        n = le * (int'(r) + 1);
        hits_exp = 0;
        hits_obs = 0;
        dexp = '0;
        dobs = '0;
        data_in = d;
        len = l;
        repeat_cnt = r;
        start = 1'b1;
        tick();
        start = keep;
        for (int i = 0; i < n; i++) begin
            b = d[le - 1 - (i % le)];
            exp_q.push_back({1'b1, b, 1'b1, 1'b0});
            dexp = {dexp[2:0], b};
            if (dexp == 4'b1101) hits_exp++;
        end
        exp_q.push_back(4'b0011);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, {bit_valid, output_bit, busy, done}, e);
            if (bit_valid) begin
                dobs = {dobs[2:0], output_bit};
                if (dobs == 4'b1101) hits_obs++;
            end
            if (disturb && k == 1) begin
                start = 1'b1;
                data_in = ~d;
                len = 5'd3;
                repeat_cnt = 4'd0;
            end
            if (disturb && k == 2) start = 1'b0;
            k++;
            tick();
        end
        chk({tag, "_idle"}, {bit_valid, output_bit, busy, done}, 4'b0000);
        chk_int({tag, "_det"}, hits_obs, hits_exp);
    endtask

    initial begin
        #12;
        chk("reset", {bit_valid, output_bit, busy, done}, 4'b0000);
        rst = 1'b1;
        tick();
        chk("post_reset", {bit_valid, output_bit, busy, done}, 4'b0000);
        xfer(16'h000D, 5'd4, 4'd0, 1'b0, 1'b0, "p1101");
        xfer(16'h000D, 5'd4, 4'd2, 1'b0, 1'b0, "p1101x3");
        xfer(16'h0000, 5'd0, 4'd0, 1'b0, 1'b0, "empty");
        xfer(16'hA5A5, 5'd20, 4'd0, 1'b0, 1'b0, "clamp");
        xfer(16'h00B6, 5'd8, 4'd1, 1'b0, 1'b1, "disturb");
        tick();
        chk("no_requeue", {bit_valid, output_bit, busy, done}, 4'b0000);
        xfer(16'h0009, 5'd4, 4'd0, 1'b1, 1'b0, "held_a");
        xfer(16'h0009, 5'd4, 4'd0, 1'b0, 1'b0, "held_b");
        data_in = 16'h000D;
        len = 5'd4;
        repeat_cnt = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_b0", {bit_valid, output_bit, busy, done}, 4'b1110);
        tick();
        tick();
        chk("abort_b2", {bit_valid, output_bit, busy, done}, 4'b1010);
        #3 rst = 1'b0;
        #1 chk("abort_async", {bit_valid, output_bit, busy, done}, 4'b0000);
        tick();
        chk("abort_hold", {bit_valid, output_bit, busy, done}, 4'b0000);
        #2 rst = 1'b1;
        tick();
        chk("abort_nodone", {bit_valid, output_bit, busy, done}, 4'b0000);
        tick();
        chk("abort_nodone2", {bit_valid, output_bit, busy, done}, 4'b0000);
        xfer(16'h000D, 5'd4, 4'd0, 1'b0, 1'b0, "restart");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
